// File: rtl/seq_divider_16bit.sv
// Radix-2 restoring divider, signed/unsigned, with start/busy/done handshake and error flag.
// Optional early termination when |divisor| > |dividend|: define DIV_EARLY_TERM_EN.
module seq_divider_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_mag_dvs;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [3:0]       r_cnt;
  logic             r_special;
  logic             r_err;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_trial;
  logic             w_early;

  assign w_dvd_neg = r_signed & r_dvd[WIDTH-1];
  assign w_dvs_neg = r_signed & r_dvs[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~r_dvd + 1'b1) : r_dvd;
  assign w_dvs_mag = w_dvs_neg ? (~r_dvs + 1'b1) : r_dvs;

  // Trial subtraction decided on the full 17-bit shifted remainder; low bits suffice once it fits.
  assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_mag_dvs});
  assign w_trial  = w_rem_sh[WIDTH-1:0] - r_mag_dvs;

`ifdef DIV_EARLY_TERM_EN
  assign w_early = (w_dvs_mag > w_dvd_mag);
`else
  assign w_early = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_signed  <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_mag_dvs <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_special <= 1'b0;
      r_err     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      Error     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_signed <= signed_op;
            r_dvd    <= dividend;
            r_dvs    <= divisor;
            busy     <= 1'b1;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_cnt     <= '0;
          r_mag_dvs <= w_dvs_mag;
          r_err     <= 1'b0;
          // Special results are parked in rem/quo and pass through FIX untouched.
          if (r_dvs == '0) begin
            r_quo     <= '1;
            r_rem     <= r_dvd;
            r_err     <= 1'b1;
            r_special <= 1'b1;
            r_state   <= S_FIX;
          end else if (r_signed && (r_dvd == MIN_NEG) && (r_dvs == '1)) begin
            r_quo     <= MIN_NEG;
            r_rem     <= '0;
            r_err     <= 1'b1;
            r_special <= 1'b1;
            r_state   <= S_FIX;
          end else if (w_early) begin
            r_quo     <= '0;
            r_rem     <= r_dvd;
            r_special <= 1'b1;
            r_state   <= S_FIX;
          end else begin
            r_quo     <= w_dvd_mag;
            r_rem     <= '0;
            r_special <= 1'b0;
            r_state   <= S_ITER;
          end
        end
        S_ITER: begin
          r_quo <= {r_quo[WIDTH-2:0], w_ge};
          r_rem <= w_ge ? w_trial : w_rem_sh[WIDTH-1:0];
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_special) begin
            quotient  <= r_quo;
            remainder <= r_rem;
          end else begin
            quotient  <= (w_dvd_neg ^ w_dvs_neg) ? (~r_quo + 1'b1) : r_quo;
            remainder <= w_dvd_neg ? (~r_rem + 1'b1) : r_rem;
          end
          Error   <= r_err;
          done    <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed-vector bench for seq_divider_16bit with hand-computed results and latencies.
module tb_seq_divider_16bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        signed_op;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        Error;

  int total = 0;
  int bad   = 0;

`ifdef DIV_EARLY_TERM_EN
  localparam int LAT_ET = 2;
`else
  localparam int LAT_ET = 18;
`endif

  seq_divider_16bit #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signed_op (signed_op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .Error     (Error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op, count edges from the accepting edge to done, then check results and hold.
  task automatic run_op(input string tag, input logic s, input logic [15:0] a, input logic [15:0] b,
                        input int lat, input logic [15:0] eq, input logic [15:0] er,
                        input logic ee, input bit poke);
    int n;
    int bcnt;
    bit got;
    @(negedge clk);
    signed_op = s; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = ~a; divisor = ~b; signed_op = ~s;
    chk({tag, "_busy_e0"}, busy, 1);
    bcnt = busy ? 1 : 0;
    n = 0; got = 0;
    while (!got && n < 40) begin
      if (poke && n == 4) begin
        start = 1'b1; dividend = 16'd1; divisor = 16'd1;
      end
      @(posedge clk); #1;
      n++;
      if (busy) bcnt++;
      if (done) got = 1;
    end
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_busy_cycles"}, bcnt, lat + 1);
    chk({tag, "_q"}, quotient, eq);
    chk({tag, "_r"}, remainder, er);
    chk({tag, "_err"}, Error, ee);
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_q_held"}, quotient, eq);
    if (poke) begin
      @(posedge clk); #1;
      chk({tag, "_no_queue"}, busy, 0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_err", Error, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op("u100_7",   1'b0, 16'd100,  16'd7,    18,     16'd14,   16'd2,    1'b0, 0);
    run_op("s-7_2",    1'b1, 16'hFFF9, 16'd2,    18,     16'hFFFD, 16'hFFFF, 1'b0, 0);
    run_op("s7_-2",    1'b1, 16'd7,    16'hFFFE, 18,     16'hFFFD, 16'd1,    1'b0, 0);
    run_op("s-100_-7", 1'b1, 16'hFF9C, 16'hFFF9, 18,     16'd14,   16'hFFFE, 1'b0, 0);
    run_op("u_div0",   1'b0, 16'h04D2, 16'd0,    2,      16'hFFFF, 16'h04D2, 1'b1, 0);
    run_op("s_div0",   1'b1, 16'hFFF9, 16'd0,    2,      16'hFFFF, 16'hFFF9, 1'b1, 0);
    run_op("s_ovf",    1'b1, 16'h8000, 16'hFFFF, 2,      16'h8000, 16'd0,    1'b1, 0);
    run_op("uFFFF_1",  1'b0, 16'hFFFF, 16'd1,    18,     16'hFFFF, 16'd0,    1'b0, 0);
    run_op("u8000_FFFF", 1'b0, 16'h8000, 16'hFFFF, LAT_ET, 16'd0,  16'h8000, 1'b0, 0);
    run_op("u3_9",     1'b0, 16'd3,    16'd9,    LAT_ET, 16'd0,    16'd3,    1'b0, 0);

    // Abort mid-iteration: count=8 is reached after the 9th edge past the accepting edge.
    @(negedge clk);
    signed_op = 1'b0; dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (n = 0; n < 9; n++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0; #2;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_err", Error, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst_50_5", 1'b0, 16'd50, 16'd5, 18, 16'd10, 16'd0, 1'b0, 0);

    run_op("busy_start", 1'b0, 16'd100, 16'd7, 18, 16'd14, 16'd2, 1'b0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
